// File: rtl/keyboard_pkg.sv
// Shared types and default rates for the keyboard UART path.
// Also holds the bit-period helper used at elaboration.
package keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned C_CLK_FRQ_DEF = 100_000_000;
  localparam int unsigned C_BAUD_DEF    = 115_200;

  // Rounded clocks-per-bit; 868 for 100 MHz / 115200.
  function automatic int unsigned bit_period(
    input int unsigned frq,
    input int unsigned baud
  );
    return (frq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte buffer between the producer and the serializer.
// Head word is presented combinationally on dout.
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];

  // Power-of-2 depth lets the pointers wrap by overflow.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer.
// The line idles high and tx comes straight from a flop.
module uart_tx
  import keyboard_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ    = C_CLK_FRQ_DEF,
  parameter int unsigned C_BAUD       = C_BAUD_DEF,
  parameter int unsigned C_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       TX_valid,
  input  logic [7:0] TX_msg,
  output logic       TX_ready,
  output logic       TX_busy,
  output logic       tx
);

  localparam int unsigned C_BIT = bit_period(C_CLK_FRQ, C_BAUD);
  localparam int unsigned CW    = $clog2(C_BIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          rdy_q;

  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic          bit_end;

  tx_fifo #(
    .DEPTH (C_FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .pop   (pop),
    .din   (TX_msg),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // rdy_q holds ready low through reset and for the release cycle.
  assign TX_ready = rdy_q & ~full;
  assign TX_busy  = (state_q != IDLE) | ~empty;
  assign tx       = tx_q;
  assign push     = TX_valid & TX_ready;
  assign bit_end  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit when data waits.
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = head;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-timing reference model, cycle-exact line check.
// Directed scenarios followed by random traffic.
module tb_uart_tx;

  localparam int CLK_F = 100_000_000;
  localparam int BAUD  = 10_000_000;
  localparam int NB    = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       TX_valid = 1'b0;
  logic [7:0] TX_msg = 8'h00;
  logic       TX_ready;
  logic       TX_busy;
  logic       tx;

  int checks = 0;
  int failures = 0;

  // Model: pending bytes, current frame byte and its start edge.
  logic [7:0] pend[$];
  logic [7:0] started[$];
  logic [7:0] rcvd[$];
  logic [7:0] cur = 8'h00;
  logic [7:0] rxsh = 8'h00;
  int         fs = 0;
  int         e = 0;
  bit         active = 0;
  bit         ready_en = 0;
  bit         acc = 0;

  uart_tx #(
    .C_CLK_FRQ    (CLK_F),
    .C_BAUD       (BAUD),
    .C_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .TX_valid (TX_valid),
    .TX_msg   (TX_msg),
    .TX_ready (TX_ready),
    .TX_busy  (TX_busy),
    .tx       (tx)
  );

  initial forever begin
    #($urandom_range(4, 6));
    clk = 1'b1;
    #5;
    clk = 1'b0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame is start(0), 8 data bits LSB first, stop(1).
  function automatic logic exp_tx();
    int k;
    if (!active) return 1'b1;
    k = (e - fs) / NB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return cur[k-1];
  endfunction

  task automatic step();
    bit rdy;
    int k;
    @(posedge clk);
    e++;
    acc = 0;
    rdy = ready_en && (pend.size() < DEPTH);
    if (active && (e - fs) == 10 * NB) active = 0;
    if (!active && pend.size() > 0) begin
      cur = pend.pop_front();
      started.push_back(cur);
      fs = e;
      active = 1;
    end
    if (TX_valid && rdy) begin
      pend.push_back(TX_msg);
      acc = 1;
    end
    ready_en = 1;
    #1;
    chk("tx", tx, exp_tx());
    chk("busy", TX_busy, active || pend.size() > 0);
    chk("ready", TX_ready, ready_en && pend.size() < DEPTH);
    if (active && (e - fs) % NB == NB / 2) begin
      k = (e - fs) / NB;
      if (k >= 1 && k <= 8) rxsh[k-1] = tx;
      if (k == 8) rcvd.push_back(rxsh);
    end
  endtask

  // Called just after a step; asserts reset mid-cycle.
  task automatic reset_mid();
    #1 rstb = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", TX_ready, 1'b0);
    chk("rst_busy", TX_busy, 1'b0);
    if (active) void'(started.pop_back());
    active = 0;
    pend.delete();
    ready_en = 0;
    repeat (3) @(posedge clk);
    #3 rstb = 1'b1;
  endtask

  initial begin
    logic [7:0] b [6];
    int idx;
    bit saw_full;
    bit hit;

    // Power-on reset
    #1 rstb = 1'b0;
    #2;
    chk("por_tx", tx, 1'b1);
    chk("por_ready", TX_ready, 1'b0);
    chk("por_busy", TX_busy, 1'b0);
    repeat (2) @(posedge clk);
    #3 rstb = 1'b1;
    step();

    // Single byte on an idle line
    TX_valid = 1'b1;
    TX_msg = 8'h7A;
    step();
    TX_valid = 1'b0;
    repeat (120) step();
    chk("s1_count", rcvd.size(), 1);
    chk("s1_byte", rcvd[0], 8'h7A);

    // Two bytes back to back
    TX_valid = 1'b1;
    TX_msg = 8'h91;
    step();
    TX_msg = 8'hA5;
    step();
    TX_valid = 1'b0;
    repeat (220) step();
    chk("s2_count", rcvd.size(), 3);
    chk("s2_byte0", rcvd[1], 8'h91);
    chk("s2_byte1", rcvd[2], 8'hA5);

    // Six distinct bytes with valid held high
    for (int i = 0; i < 6; i++) b[i] = {4'($urandom), 4'(i)};
    idx = 0;
    saw_full = 0;
    TX_valid = 1'b1;
    TX_msg = b[0];
    for (int n = 0; n < 2000 && idx < 6; n++) begin
      step();
      if (!TX_ready) saw_full = 1;
      if (acc) begin
        idx++;
        if (idx < 6) TX_msg = b[idx];
      end
    end
    TX_valid = 1'b0;
    chk("s3_accepted", idx, 6);
    chk("s3_ready_drop", saw_full, 1'b1);
    repeat (700) step();
    chk("s3_count", rcvd.size(), 9);
    for (int i = 0; i < 6; i++) chk("s3_byte", rcvd[3+i], b[i]);

    // Reset during data bit 3 (chosen low so tx visibly rises)
    TX_valid = 1'b1;
    TX_msg = 8'($urandom) & 8'hF7;
    step();
    TX_valid = 1'b0;
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      step();
      if (active && (e - fs) == 4 * NB + 3) hit = 1;
    end
    chk("s4_reach_bit3", hit, 1'b1);
    chk("s4_tx_low", tx, 1'b0);
    reset_mid();
    step();
    TX_valid = 1'b1;
    TX_msg = 8'($urandom);
    step();
    TX_valid = 1'b0;
    repeat (110) step();
    chk("s4_after_rst", rcvd[rcvd.size()-1], started[started.size()-1]);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      TX_valid = ($urandom_range(0, 9) == 0);
      TX_msg = 8'($urandom);
      step();
    end
    TX_valid = 1'b0;
    repeat (600) step();

    chk("rx_total", rcvd.size(), started.size());
    for (int i = 0; i < rcvd.size() && i < started.size(); i++)
      chk("rx_byte", rcvd[i], started[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter C_CLK_FRQ, default 100_000_000, giving the main clock frequency in Hz.
REQ-002 The module SHALL have parameter C_BAUD, default 115_200, giving the serial line rate in bit/s.
REQ-003 The module SHALL have parameter C_FIFO_DEPTH, default 4, giving the byte buffer depth; it SHALL be a power of 2 and at least 2.
REQ-004 Port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rstb, input, 1 bit: the reset; it SHALL be asynchronous and active-low.
REQ-006 Port TX_valid, input, 1 bit: byte offered by the producer.
REQ-007 Port TX_msg, input, 8 bits: the byte to send.
REQ-008 Port TX_ready, output, 1 bit: the buffer can accept a byte.
REQ-009 Port TX_busy, output, 1 bit: a frame is on the line or the buffer is non-empty.
REQ-010 Port tx, output, 1 bit: the serial line; it SHALL idle high.

Function
REQ-011 The bit period SHALL be C_BIT = round(C_CLK_FRQ / C_BAUD) clock cycles, computed at elaboration (868 for the defaults).
REQ-012 A byte SHALL be accepted on a rising edge where TX_valid=1 and TX_ready=1; TX_msg SHALL be written into the FIFO on that edge.
REQ-013 TX_ready SHALL equal NOT(FIFO full); a TX_valid asserted while TX_ready=0 SHALL be ignored, and no data SHALL be lost or overwritten.
REQ-014 A push and a pop on the same edge SHALL both take effect, leaving the occupancy unchanged.
REQ-015 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-016 IDLE -> START SHALL occur on the first edge where the FIFO is non-empty; on that edge the head byte SHALL be popped into a shift register.
REQ-017 In START, tx SHALL be 0 for exactly C_BIT cycles, then the FSM SHALL go to DATA.
REQ-018 In DATA, tx SHALL carry 8 bits LSB first, each for exactly C_BIT cycles; a 3-bit index SHALL advance, and after bit 7 the FSM SHALL go to STOP.
REQ-019 In STOP, tx SHALL be 1 for exactly C_BIT cycles; at the end, if the FIFO is non-empty the FSM SHALL pop and re-enter START with no idle gap, otherwise it SHALL return to IDLE.
REQ-020 Latency: if the FIFO is empty and the FSM is in IDLE, a byte accepted at edge k SHALL make tx fall at edge k+1.
REQ-021 A frame SHALL last exactly 10*C_BIT cycles.
REQ-022 tx SHALL be driven from a register and SHALL never glitch.
REQ-023 TX_busy SHALL be 1 whenever the state is not IDLE or the FIFO is non-empty.
REQ-024 The FIFO read and write pointers SHALL wrap modulo C_FIFO_DEPTH.
REQ-025 Full and empty SHALL be distinguished using an occupancy count of width log2(C_FIFO_DEPTH)+1.

Reset
REQ-026 While rstb=0, the outputs SHALL be tx=1, TX_ready=0 and TX_busy=0; the state SHALL be IDLE and the FIFO SHALL be empty with pointers and counters at 0.
REQ-027 A reset asserted mid-frame SHALL immediately force tx=1 and discard the partial frame and all buffered bytes.
REQ-028 TX_ready SHALL rise on the first edge after rstb deasserts.

Structure
REQ-029 The package keyboard_pkg SHALL hold the FSM state enum (IDLE/START/DATA/STOP) and the default C_CLK_FRQ and C_BAUD constants.
REQ-030 The buffer SHALL be a separate sub-module, tx_fifo, parameterised by depth and width, exposing push, pop, din, dout, full, empty and rstb.
REQ-031 The bit-period counter and the FSM SHALL reside in uart_tx.

Verification
REQ-032 The bench SHALL use C_CLK_FRQ=100_000_000 and C_BAUD=10_000_000, so C_BIT=10, with the same jittered clock generation as the control bench.
REQ-033 Scenario: send 8'h7A on an idle line -> tx falls 1 cycle after acceptance; bits read 0,0,1,0,1,1,1,1,0 then 1, each bit 10 cycles; TX_busy falls after 100 cycles.
REQ-034 Scenario: push 8'h91 and 8'hA5 on consecutive cycles -> two frames of 100 cycles each back-to-back, with the second start bit at cycle 100 after the first, and no high gap between them.
REQ-035 Scenario: hold TX_valid=1 with 6 distinct bytes -> TX_ready drops when 4 bytes are buffered; all 6 bytes are sent in order and none is dropped or duplicated.
REQ-036 Scenario: assert rstb=0 during DATA bit 3 -> tx=1 within the same cycle; after release TX_busy=0 and the next pushed byte is sent cleanly.
REQ-037 Scenario: loop tx back into the existing UART receiver and the control block -> UART_msg matches every byte sent and UART_err stays 0.
